// File: rtl/video_timing_gen.sv
// Programmable raster timing generator.
// A clock-enable divider produces one ce_pix strobe every CE_DIV clk_vid
// cycles. Each strobe advances the horizontal and vertical pixel counters.
// The sync, blank and count outputs are all registered on that same edge,
// so a consumer that samples on ce_pix always sees one consistent pixel.
// VSync is re-evaluated only at the HSync leading edge, which keeps the two
// syncs phase-aligned.
module video_timing_gen #(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk_vid,
    input  logic        reset,
    input  logic        enable,
    output logic        ce_pix,
    output logic        HSync,
    output logic        VSync,
    output logic        HBlank,
    output logic        VBlank,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        frame_start
);

    // Derived raster geometry, computed in full integer width so that the
    // range check below sees the true values.
    localparam int H_TOTAL_I  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_I  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START_I = H_ACTIVE + H_FP;
    localparam int HS_END_I   = HS_START_I + H_SYNC;
    localparam int VS_START_I = V_ACTIVE + V_FP;
    localparam int VS_END_I   = VS_START_I + V_SYNC;

    // Refuse to elaborate when the raster does not fit the 12-bit counters.
    generate
        if (CE_DIV < 1 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
            H_FP < 0 || H_SYNC < 0 || H_BP < 0 ||
            V_FP < 0 || V_SYNC < 0 || V_BP < 0 ||
            H_TOTAL_I > 4095 || V_TOTAL_I > 4095) begin : g_bad_params
            $error("video_timing_gen: illegal timing parameters");
        end
    endgenerate

    // The same constants, sized to match the counters.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL_I - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL_I - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(HS_START_I);
    localparam logic [11:0] HS_END   = 12'(HS_END_I);
    localparam logic [11:0] VS_START = 12'(VS_START_I);
    localparam logic [11:0] VS_END   = 12'(VS_END_I);

    // Active levels of the syncs.
    localparam logic HS_ON  = 1'(HS_POL);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = 1'(VS_POL);
    localparam logic VS_OFF = ~VS_ON;

    // The divider needs at least one bit, even when CE_DIV is 1.
    localparam int              DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    logic [DIV_W-1:0] divider;
    logic             h_wrap;
    logic [11:0]      h_next;
    logic [11:0]      v_next;

    // Next pixel position: the column wraps at the end of the line, and the
    // row moves on only at that wrap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so that no path leaves it unassigned and no latch is inferred.
        h_wrap = 1'b0;
        h_next = hcount + 12'd1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_wrap = 1'b1;
            h_next = '0;
            v_next = (vcount == V_LAST) ? 12'd0 : vcount + 12'd1;
        end
    end

    // Divider, counters and every registered output. Clearing enable freezes
    // all state except the two strobes, which drop to 0.
    always_ff @(posedge clk_vid or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before this clock edge.
        if (reset) begin
            divider     <= '0;
            ce_pix      <= 1'b0;
            frame_start <= 1'b0;
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            HSync       <= HS_OFF;
            VSync       <= VS_OFF;
            HBlank      <= 1'b1;
            VBlank      <= 1'b1;
        end else if (enable) begin
            if (divider == DIV_LAST) begin
                divider     <= '0;
                ce_pix      <= 1'b1;
                hcount      <= h_next;
                HBlank      <= (h_next >= H_ACT);
                HSync       <= (h_next >= HS_START && h_next < HS_END) ? HS_ON : HS_OFF;
                frame_start <= (h_next == 12'd0) && (v_next == 12'd0);
                if (h_wrap) begin
                    vcount <= v_next;
                    VBlank <= (v_next >= V_ACT);
                end
                // VSync is updated only together with the HSync leading edge.
                if (h_next == HS_START) begin
                    VSync <= (v_next >= VS_START && v_next < VS_END) ? VS_ON : VS_OFF;
                end
            end else begin
                divider     <= divider + 1'b1;
                ce_pix      <= 1'b0;
                frame_start <= 1'b0;
            end
        end else begin
            ce_pix      <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed testbench for video_timing_gen.
// Three instances share one clock: the default 640x480 timing, a CE_DIV=1
// positive-polarity variant with a short frame, and a tiny raster that
// exercises frame-level timing in a few hundred clocks.
module tb_video_timing_gen;

    logic clk_vid = 1'b0;
    always #5 clk_vid = ~clk_vid;

    int checks   = 0;
    int failures = 0;

    // Default instance
    logic        rst_d = 1'b1, en_d = 1'b1;
    logic        ce_d, hs_d, vs_d, hb_d, vb_d, fs_d;
    logic [11:0] hc_d, vc_d;

    // CE_DIV=1, positive syncs, 8-line frame
    logic        rst_p = 1'b1, en_p = 1'b1;
    logic        ce_p, hs_p, vs_p, hb_p, vb_p, fs_p;
    logic [11:0] hc_p, vc_p;

    // Small raster: 16 pixels x 12 lines, CE_DIV=2
    logic        rst_s = 1'b1, en_s = 1'b1;
    logic        ce_s, hs_s, vs_s, hb_s, vb_s, fs_s;
    logic [11:0] hc_s, vc_s;

    video_timing_gen dut_d (
        .clk_vid(clk_vid), .reset(rst_d), .enable(en_d),
        .ce_pix(ce_d), .HSync(hs_d), .VSync(vs_d), .HBlank(hb_d), .VBlank(vb_d),
        .hcount(hc_d), .vcount(vc_d), .frame_start(fs_d)
    );

    video_timing_gen #(
        .CE_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1)
    ) dut_p (
        .clk_vid(clk_vid), .reset(rst_p), .enable(en_p),
        .ce_pix(ce_p), .HSync(hs_p), .VSync(vs_p), .HBlank(hb_p), .VBlank(vb_p),
        .hcount(hc_p), .vcount(vc_p), .frame_start(fs_p)
    );

    video_timing_gen #(
        .CE_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk_vid(clk_vid), .reset(rst_s), .enable(en_s),
        .ce_pix(ce_s), .HSync(hs_s), .VSync(vs_s), .HBlank(hb_s), .VBlank(vb_s),
        .hcount(hc_s), .vcount(vc_s), .frame_start(fs_s)
    );

    // One comparison: counts it, and on mismatch counts and reports a failure.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge before sampling.
    task automatic step(input int n);
        repeat (n) @(posedge clk_vid);
        #1;
    endtask

    int d_pos, s_pos;
    int ce_seen, hc_moved;
    int e_ce, e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_fs, n_hs, n_vs;
    int h, v;
    logic exp_hs, exp_vs;

    initial begin
        // ---------------- reset state ----------------
        step(2);
        check("rst_ce",     ce_d, 0);
        check("rst_fs",     fs_d, 0);
        check("rst_hcount", hc_d, 799);
        check("rst_vcount", vc_d, 524);
        check("rst_hsync",  hs_d, 1);
        check("rst_vsync",  vs_d, 1);
        check("rst_hblank", hb_d, 1);
        check("rst_vblank", vb_d, 1);
        check("rst_hsync_pos_pol", hs_p, 0);
        check("rst_vsync_pos_pol", vs_p, 0);

        // ---------------- first pixel after release ----------------
        rst_d = 1'b0;
        step(3);
        check("no_ce_before_4th", ce_d, 0);
        step(1);
        check("first_ce",     ce_d, 1);
        check("first_hcount", hc_d, 0);
        check("first_vcount", vc_d, 0);
        check("first_fs",     fs_d, 1);
        check("first_hblank", hb_d, 0);
        check("first_vblank", vb_d, 0);
        check("first_hsync",  hs_d, 1);
        d_pos = 0;

        // ce_pix period of 4 clocks
        step(3);
        check("ce_gap", ce_d, 0);
        step(1);
        check("ce_period", ce_d, 1);
        check("second_hcount", hc_d, 1);
        check("second_fs", fs_d, 0);
        d_pos = 1;

        // ---------------- line timing ----------------
        step(4 * (639 - d_pos)); d_pos = 639;
        check("hblank_639", hb_d, 0);
        check("hcount_639", hc_d, 639);
        step(4); d_pos = 640;
        check("hblank_640", hb_d, 1);
        step(4 * 15); d_pos = 655;
        check("hsync_655", hs_d, 1);
        step(4); d_pos = 656;
        check("hsync_656", hs_d, 0);
        step(4 * 95); d_pos = 751;
        check("hsync_751", hs_d, 0);
        step(4); d_pos = 752;
        check("hsync_752", hs_d, 1);
        step(4 * 47); d_pos = 799;
        check("hcount_799", hc_d, 799);
        check("vcount_line0", vc_d, 0);
        step(4); d_pos = 800;
        check("hwrap_hcount", hc_d, 0);
        check("hwrap_vcount", vc_d, 1);
        check("hwrap_hblank", hb_d, 0);
        check("hwrap_fs", fs_d, 0);
        // exactly one line period (3200 clocks) later
        step(3200); d_pos = 1600;
        check("line_period_hcount", hc_d, 0);
        check("line_period_vcount", vc_d, 2);
        check("line_period_ce", ce_d, 1);

        // ---------------- enable hold at hcount 100 ----------------
        step(400); d_pos = 1700;
        check("hold_start_hcount", hc_d, 100);
        step(2);
        en_d = 1'b0;
        ce_seen = 0;
        hc_moved = 0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            if (ce_d) ce_seen++;
            if (hc_d != 12'd100) hc_moved++;
        end
        check("hold_no_ce", ce_seen, 0);
        check("hold_hcount_frozen", hc_moved, 0);
        check("hold_vcount", vc_d, 2);
        check("hold_hblank", hb_d, 0);
        check("hold_hsync", hs_d, 1);
        en_d = 1'b1;
        step(1);
        check("resume_phase_gap", ce_d, 0);
        step(1);
        check("resume_ce", ce_d, 1);
        check("resume_hcount", hc_d, 101);
        d_pos = 1701;

        // ---------------- asynchronous reset mid-frame ----------------
        #3;
        rst_d = 1'b1;
        #1;
        check("async_rst_ce", ce_d, 0);
        check("async_rst_hcount", hc_d, 799);
        check("async_rst_vcount", vc_d, 524);
        check("async_rst_hblank", hb_d, 1);
        check("async_rst_vblank", vb_d, 1);
        check("async_rst_hsync", hs_d, 1);
        step(2);
        rst_d = 1'b0;
        step(3);
        check("rerst_no_fs_yet", fs_d, 0);
        step(1);
        check("rerst_fs", fs_d, 1);
        check("rerst_hcount", hc_d, 0);
        check("rerst_vcount", vc_d, 0);

        // ---------------- CE_DIV=1, positive polarity, full frame ----------------
        rst_p = 1'b0;
        e_ce = 0; e_hc = 0; e_vc = 0; e_hs = 0; e_vs = 0;
        e_hb = 0; e_vb = 0; e_fs = 0; n_hs = 0; n_vs = 0;
        for (int i = 0; i < 6400; i++) begin
            step(1);
            h = i % 800;
            v = i / 800;
            exp_hs = (h >= 656 && h < 752);
            exp_vs = (i >= 5 * 800 + 656 && i < 7 * 800 + 656);
            if (ce_p !== 1'b1) e_ce++;
            if (hc_p !== 12'(h)) e_hc++;
            if (vc_p !== 12'(v)) e_vc++;
            if (hs_p !== exp_hs) e_hs++;
            if (vs_p !== exp_vs) e_vs++;
            if (hb_p !== (h >= 640)) e_hb++;
            if (vb_p !== (v >= 4)) e_vb++;
            if (fs_p !== (i == 0)) e_fs++;
            if (hs_p) n_hs++;
            if (vs_p) n_vs++;
        end
        check("p_ce_always_high", e_ce, 0);
        check("p_hcount_errors", e_hc, 0);
        check("p_vcount_errors", e_vc, 0);
        check("p_hsync_errors", e_hs, 0);
        check("p_vsync_errors", e_vs, 0);
        check("p_hblank_errors", e_hb, 0);
        check("p_vblank_errors", e_vb, 0);
        check("p_fs_errors", e_fs, 0);
        check("p_hsync_high_clocks", n_hs, 96 * 8);
        check("p_vsync_high_clocks", n_vs, 2 * 800);
        step(1);
        check("p_frame_period_fs", fs_p, 1);
        check("p_frame_period_hcount", hc_p, 0);
        check("p_frame_period_vcount", vc_p, 0);

        // ---------------- small raster: frame-level timing ----------------
        rst_s = 1'b0;
        step(2); s_pos = 0;
        check("s_first_fs", fs_s, 1);
        check("s_first_hcount", hc_s, 0);
        step(2 * (95 - s_pos)); s_pos = 95;
        check("s_vblank_before", vb_s, 0);
        check("s_vcount_5", vc_s, 5);
        step(2); s_pos = 96;
        check("s_vblank_rise", vb_s, 1);
        check("s_vcount_6", vc_s, 6);
        check("s_hcount_wrap", hc_s, 0);
        check("s_hsync_line_start", hs_s, 1);
        step(2 * (137 - s_pos)); s_pos = 137;
        check("s_vsync_before_fall", vs_s, 1);
        step(2); s_pos = 138;
        check("s_vsync_fall", vs_s, 0);
        check("s_hsync_with_vsync", hs_s, 0);
        check("s_hcount_hs_start", hc_s, 10);
        step(2 * (169 - s_pos)); s_pos = 169;
        check("s_vsync_before_rise", vs_s, 0);
        step(2); s_pos = 170;
        check("s_vsync_rise", vs_s, 1);
        check("s_vcount_10", vc_s, 10);
        step(2 * (191 - s_pos)); s_pos = 191;
        check("s_last_pixel_fs", fs_s, 0);
        check("s_last_pixel_h", hc_s, 15);
        check("s_last_pixel_v", vc_s, 11);
        step(2); s_pos = 192;
        check("s_frame_period_fs", fs_s, 1);
        check("s_frame_period_h", hc_s, 0);
        check("s_frame_period_v", vc_s, 0);
        check("s_frame_vblank", vb_s, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Programmable raster timing source: pixel-enable divider plus horizontal/vertical counters.
- Generates HSync, VSync, HBlank and VBlank with fixed polarity and clean phase alignment.
- Sits upstream of the video cleaner / scandoubler path. Drives the core's pixel pipeline and supplies the sync/blank bundle the downstream video stage consumes.
- VSync edges are aligned to the HSync leading edge by construction.

Parameters:
- CE_DIV, 4: clk_vid cycles per pixel (>=1).
- H_ACTIVE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: HSync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: VSync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: HSync active level (0 = active low).
- VS_POL, 0: VSync active level.

Ports:
- clk_vid input 1: video clock.
- reset input 1: asynchronous, active-high reset.
- enable input 1: run; when low, all state freezes.
- ce_pix output 1: one-clk_vid pixel strobe.
- HSync output 1: horizontal sync at HS_POL.
- VSync output 1: vertical sync at VS_POL.
- HBlank output 1: high outside active pixels.
- VBlank output 1: high outside active lines.
- hcount output 12: current pixel index, 0..H_TOTAL-1.
- vcount output 12: current line index, 0..V_TOTAL-1.
- frame_start output 1: high for the ce_pix cycle of pixel (0,0).

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - HS_START = H_ACTIVE+H_FP; HS_END = HS_START+H_SYNC.
  - VS_START = V_ACTIVE+V_FP; VS_END = VS_START+V_SYNC.
  - All must fit in 12 bits; otherwise elaboration fails.
- Reset (async, asserted) values:
  - divider = 0, ce_pix = 0, frame_start = 0.
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1.
  - HSync = VSync = inactive levels (~HS_POL, ~VS_POL).
  - HBlank = VBlank = 1.
  - Reset release takes effect on the next rising clk_vid edge.
- All outputs are registered. No combinational path from any input to any output.
- Divider:
  - Counts 0..CE_DIV-1 while enable = 1.
  - On the edge where divider == CE_DIV-1: divider <= 0, ce_pix <= 1. Otherwise ce_pix <= 0.
  - CE_DIV = 1: ce_pix is high every enabled cycle.
- Pixel advance happens on the same edge that sets ce_pix. All counter/sync/blank outputs update together, so a consumer sampling on ce_pix sees a consistent pixel.
- Pixel advance:
  - hcount wraps H_TOTAL-1 -> 0.
  - On that wrap only, vcount increments, wrapping V_TOTAL-1 -> 0.
- HBlank = (new hcount >= H_ACTIVE).
- HSync active when HS_START <= new hcount < HS_END.
- VBlank = (new vcount >= V_ACTIVE). It changes only on the hcount wrap edge.
- VSync:
  - Changes only on the pixel advance where new hcount == HS_START, i.e. coincident with the HSync leading edge.
  - Value there: active when VS_START <= vcount < VS_END.
  - Result: VSync spans exactly V_SYNC lines, HSync-edge to HSync-edge.
- frame_start is high on the advance where new (hcount, vcount) == (0,0); low otherwise.
- First ce_pix after reset presents pixel (0,0) with frame_start = 1, HBlank = 0, VBlank = 0.
- enable = 0:
  - Divider, counters and all sync/blank/count outputs hold.
  - ce_pix and frame_start are forced 0 on the next edge.
  - Resuming continues from the held divider phase; no pixel is skipped or repeated.
- Reset mid-frame: immediate return to reset values. The next frame starts cleanly at (0,0).
- H_SYNC = 0 or V_SYNC = 0 is permitted: that sync never asserts; counters are unaffected.

Test Plan:
- Defaults, reset released, enable = 1:
  - First ce_pix on 4th clk after release, with hcount = 0, vcount = 0, frame_start = 1, HBlank = 0, VBlank = 0.
  - ce_pix period is exactly 4 clocks.
- Line timing, defaults:
  - HBlank rises at hcount 640.
  - HSync goes low at hcount 656 and high at hcount 752.
  - hcount wraps 799 -> 0.
  - Line period = 3200 clk_vid.
- Frame timing:
  - VBlank rises on the wrap into vcount 480.
  - VSync falls at the hcount = 656 advance of line 490 and rises at the hcount = 656 advance of line 492.
  - frame_start period = 1,680,000 clk_vid.
- enable = 0 held for 37 clocks mid-line at hcount = 100:
  - No ce_pix during the hold; outputs unchanged.
  - After re-enable, next ce_pix shows hcount = 101 and the divider phase is preserved.
- reset pulsed asynchronously (mid-clock) at vcount = 300:
  - Outputs go to reset values immediately.
  - Next frame_start arrives 4 clocks after release.
- CE_DIV = 1, HS_POL = 1, VS_POL = 1:
  - ce_pix is constantly high.
  - HSync is high for hcount 656..751.
  - VSync is high for 2 lines.
  - Frame = 420,000 clocks.
